// File: rtl/me_pkg.sv
// Shared FSM encoding and derived-width helper for the full-search motion estimator.
package me_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ceil(log2(v)), never below 1 so single-step counters keep a real bit
  function automatic int me_bits(input int v);
    int b;
    int p;
    b = 32'sd1;
    p = 32'sd2;
    while (p < v) begin
      p = p * 32'sd2;
      b = b + 32'sd1;
    end
    return b;
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Raster scan address generator: cy, cx, py, px counters and the R/S read addresses.
// skip_i abandons the current candidate and restarts at pixel 0 of the next one.
module me_addr_gen
  import me_pkg::*;
#(
  parameter int BLK   = 16,
  parameter int RANGE = 8,
  parameter int WIN   = BLK + 32'sd2 * RANGE - 32'sd1,
  parameter int PW    = me_bits(BLK),
  parameter int CW    = me_bits(32'sd2 * RANGE),
  parameter int RA_W  = me_bits(BLK * BLK),
  parameter int SA_W  = me_bits(WIN * WIN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            skip_i,
  output logic            valid_o,
  output logic [RA_W-1:0] addr_r_o,
  output logic [SA_W-1:0] addr_s_o,
  output logic [CW-1:0]   cx_o,
  output logic [CW-1:0]   cy_o,
  output logic            first_pix_o,
  output logic            last_pix_o,
  output logic            last_cand_o,
  output logic            issue_end_o
);

  logic [PW-1:0]   px_q, px_d, py_q, py_d;
  logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic            vld_q, vld_d;
  logic [RA_W-1:0] ar_q, ar_d;
  logic [SA_W-1:0] as_q, as_d;
  logic            pix_last_s, cand_last_s, issue_end_s;

  assign pix_last_s  = (px_q == PW'(BLK - 32'sd1)) && (py_q == PW'(BLK - 32'sd1));
  assign cand_last_s = (cx_q == CW'(32'sd2 * RANGE - 32'sd1)) && (cy_q == CW'(32'sd2 * RANGE - 32'sd1));
  assign issue_end_s = vld_q && cand_last_s && (pix_last_s || skip_i);

  // Next scan position; addresses follow the counters so they hold once the scan stops.
  always_comb begin
    px_d  = px_q;
    py_d  = py_q;
    cx_d  = cx_q;
    cy_d  = cy_q;
    vld_d = vld_q;
    if (load_i) begin
      px_d  = '0;
      py_d  = '0;
      cx_d  = '0;
      cy_d  = '0;
      vld_d = 1'b1;
    end else if (step_i && vld_q) begin
      if (issue_end_s) begin
        vld_d = 1'b0;
      end else if (pix_last_s || skip_i) begin
        px_d = '0;
        py_d = '0;
        if (cx_q == CW'(32'sd2 * RANGE - 32'sd1)) begin
          cx_d = '0;
          cy_d = cy_q + CW'(1'b1);
        end else begin
          cx_d = cx_q + CW'(1'b1);
        end
      end else if (px_q == PW'(BLK - 32'sd1)) begin
        px_d = '0;
        py_d = py_q + PW'(1'b1);
      end else begin
        px_d = px_q + PW'(1'b1);
      end
    end else begin
      vld_d = vld_q;
    end
    ar_d = {py_d, px_d};
    as_d = SA_W'((int'(cy_d) + int'(py_d)) * WIN + int'(cx_d) + int'(px_d));
  end

  // Scan counter and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q  <= '0;
      py_q  <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      vld_q <= 1'b0;
      ar_q  <= '0;
      as_q  <= '0;
    end else begin
      px_q  <= px_d;
      py_q  <= py_d;
      cx_q  <= cx_d;
      cy_q  <= cy_d;
      vld_q <= vld_d;
      ar_q  <= ar_d;
      as_q  <= as_d;
    end
  end

  assign valid_o     = vld_q;
  assign addr_r_o    = ar_q;
  assign addr_s_o    = as_q;
  assign cx_o        = cx_q;
  assign cy_o        = cy_q;
  assign first_pix_o = (px_q == '0) && (py_q == '0);
  assign last_pix_o  = pix_last_s;
  assign last_cand_o = cand_last_s;
  assign issue_end_o = issue_end_s;

endmodule

// File: rtl/me_fullsearch_core.sv
// Full-search block-matching motion estimator, one pixel per cycle, minimum-SAD vector out.
// Optional feature macro: ME_EARLY_TERM_EN (abandon candidates whose partial SAD exceeds the best).
module me_fullsearch_core
  import me_pkg::*;
#(
  parameter  int PIX_W  = 8,
  parameter  int BLK    = 16,
  parameter  int RANGE  = 8,
  localparam int WIN    = BLK + 32'sd2 * RANGE - 32'sd1,
  localparam int MV_W   = me_bits(32'sd2 * RANGE) + 32'sd1,
  localparam int DIST_W = PIX_W + 32'sd2 * me_bits(BLK),
  localparam int RA_W   = me_bits(BLK * BLK),
  localparam int SA_W   = me_bits(WIN * WIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [RA_W-1:0]   addr_r,
  input  logic [PIX_W-1:0]  r_data,
  output logic [SA_W-1:0]   addr_s,
  input  logic [PIX_W-1:0]  s_data,
  output logic [DIST_W-1:0] best_dist,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y
);

  localparam int CW = me_bits(32'sd2 * RANGE);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              busy_q, done_q, final_q;
  logic              load_s, step_s, skip_s;
  logic              ag_valid_s, ag_first_s, ag_lastpix_s, ag_lastcand_s, ag_end_s;
  logic [CW-1:0]     ag_cx_s, ag_cy_s;
  logic              v1_q, first1_q, lastpix1_q, lastcand1_q;
  logic [CW-1:0]     cx1_q, cy1_q;
  logic              v2_q, lastpix2_q, lastcand2_q;
  logic [CW-1:0]     cx2_q, cy2_q;
  logic [DIST_W-1:0] acc_q, acc_d, best_q, best_d;
  logic [MV_W-1:0]   mvx_q, mvx_d, mvy_q, mvy_d;
  logic              best_vld_q, best_vld_d;
  logic              abort_s, kill0_s, kill1_s, cand_end_s, final_s;

  assign load_s = (state_q == ST_IDLE) && start;
  assign step_s = (state_q == ST_RUN);
  assign skip_s = kill0_s;

  me_addr_gen #(
    .BLK   (BLK),
    .RANGE (RANGE),
    .WIN   (WIN),
    .CW    (CW),
    .RA_W  (RA_W),
    .SA_W  (SA_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_s),
    .step_i      (step_s),
    .skip_i      (skip_s),
    .valid_o     (ag_valid_s),
    .addr_r_o    (addr_r),
    .addr_s_o    (addr_s),
    .cx_o        (ag_cx_s),
    .cy_o        (ag_cy_s),
    .first_pix_o (ag_first_s),
    .last_pix_o  (ag_lastpix_s),
    .last_cand_o (ag_lastcand_s),
    .issue_end_o (ag_end_s)
  );

`ifdef ME_EARLY_TERM_EN
  // Equal partials run to completion; only a strictly worse partial can never win or tie.
  assign abort_s = v2_q && !lastpix2_q && best_vld_q && (acc_q > best_q);
  assign kill1_s = abort_s && ({cy1_q, cx1_q} == {cy2_q, cx2_q});
  assign kill0_s = abort_s && ({ag_cy_s, ag_cx_s} == {cy2_q, cx2_q});
`else
  assign abort_s = 1'b0;
  assign kill1_s = 1'b0;
  assign kill0_s = 1'b0;
`endif

  assign cand_end_s = v2_q && lastpix2_q;
  assign final_s    = v2_q && lastcand2_q && (lastpix2_q || abort_s);

  // Control sequencing: scan, wait for the pipeline to empty, one-cycle done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_RUN;   else state_d = ST_IDLE;
      ST_RUN:   if (ag_end_s) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: if (final_q)  state_d = ST_DONE;  else state_d = ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Running SAD and best-so-far selection; the first candidate of a run always loads.
  always_comb begin
    acc_d      = acc_q;
    best_d     = best_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;
    best_vld_d = best_vld_q;
    if (v1_q && !kill1_s) begin
      if (first1_q) acc_d = DIST_W'(abs_diff(r_data, s_data));
      else          acc_d = acc_q + DIST_W'(abs_diff(r_data, s_data));
    end else begin
      acc_d = acc_q;
    end
    if (load_s) begin
      best_vld_d = 1'b0;
    end else if (cand_end_s) begin
      best_vld_d = 1'b1;
      if (!best_vld_q || (acc_q < best_q)) begin
        best_d = acc_q;
        mvx_d  = {1'b0, cx2_q} - MV_W'(RANGE);
        mvy_d  = {1'b0, cy2_q} - MV_W'(RANGE);
      end else begin
        best_d = best_q;
      end
    end else begin
      best_vld_d = best_vld_q;
    end
  end

  // FSM and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
      final_q <= final_s;
    end
  end

  // Read-latency pipeline tags and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      lastpix1_q  <= 1'b0;
      lastcand1_q <= 1'b0;
      cx1_q       <= '0;
      cy1_q       <= '0;
      v2_q        <= 1'b0;
      lastpix2_q  <= 1'b0;
      lastcand2_q <= 1'b0;
      cx2_q       <= '0;
      cy2_q       <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      mvx_q       <= '0;
      mvy_q       <= '0;
      best_vld_q  <= 1'b0;
    end else begin
      v1_q        <= ag_valid_s && !kill0_s;
      first1_q    <= ag_first_s;
      lastpix1_q  <= ag_lastpix_s;
      lastcand1_q <= ag_lastcand_s;
      cx1_q       <= ag_cx_s;
      cy1_q       <= ag_cy_s;
      v2_q        <= v1_q && !kill1_s;
      lastpix2_q  <= lastpix1_q;
      lastcand2_q <= lastcand1_q;
      cx2_q       <= cx1_q;
      cy2_q       <= cy1_q;
      acc_q       <= acc_d;
      best_q      <= best_d;
      mvx_q       <= mvx_d;
      mvy_q       <= mvy_d;
      best_vld_q  <= best_vld_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign best_dist = best_q;
  assign mv_x      = mvx_q;
  assign mv_y      = mvy_q;

endmodule

// File: tb/tb_me_fullsearch_core.sv
// Self-checking bench for me_fullsearch_core (BLK=4, RANGE=2) against a plain-arithmetic SAD search model.
`timescale 1ns/1ps
module tb_me_fullsearch_core;

  localparam int PIX_W  = 8;
  localparam int BLK    = 4;
  localparam int RANGE  = 2;
  localparam int WIN    = 7;
  localparam int NCAND  = 16;
  localparam int LAT    = NCAND * BLK * BLK + 3;
  localparam int MV_W   = 3;
  localparam int DIST_W = 12;
  localparam int RA_W   = 4;
  localparam int SA_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [RA_W-1:0]   addr_r;
  logic [SA_W-1:0]   addr_s;
  logic [PIX_W-1:0]  r_data = '0;
  logic [PIX_W-1:0]  s_data = '0;
  logic [DIST_W-1:0] best_dist;
  logic [MV_W-1:0]   mv_x, mv_y;

  logic [7:0] r_mem [BLK*BLK];
  logic [7:0] s_mem [WIN*WIN];

  int n_cmp = 0;
  int n_fail = 0;
  int lat1, lat2, lat3, latx;

  me_fullsearch_core #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .addr_r(addr_r), .r_data(r_data), .addr_s(addr_s), .s_data(s_data),
    .best_dist(best_dist), .mv_x(mv_x), .mv_y(mv_y)
  );

  always #5 clk = ~clk;

  // Synchronous frame-buffer RAMs with one cycle of read latency.
  always @(posedge clk) begin
    r_data <= r_mem[addr_r];
    s_data <= s_mem[addr_s];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exhaustive search straight from the definition: first minimum in scan order wins.
  task automatic model(output int bd, output int bmx, output int bmy);
    int best, sad, a, b;
    best = -1; bmx = 0; bmy = 0;
    for (int cy = 0; cy < 2*RANGE; cy++)
      for (int cx = 0; cx < 2*RANGE; cx++) begin
        sad = 0;
        for (int py = 0; py < BLK; py++)
          for (int px = 0; px < BLK; px++) begin
            a = int'(r_mem[py*BLK + px]);
            b = int'(s_mem[(cy+py)*WIN + cx + px]);
            sad += (a > b) ? (a - b) : (b - a);
          end
        if (best < 0 || sad < best) begin
          best = sad; bmx = cx - RANGE; bmy = cy - RANGE;
        end
      end
    bd = best;
  endtask

  task automatic fill_const(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < BLK*BLK; i++) r_mem[i] = rv;
    for (int i = 0; i < WIN*WIN; i++) s_mem[i] = sv;
  endtask

  task automatic fill_rand(input int maxv);
    for (int i = 0; i < BLK*BLK; i++) r_mem[i] = 8'($urandom_range(0, maxv));
    for (int i = 0; i < WIN*WIN; i++) s_mem[i] = 8'($urandom_range(0, maxv));
  endtask

  // One complete run; pa/pb are edges at which a stray start is presented (-1 = none).
  task automatic run_test(input string tag, input int pa, input int pb, output int lat);
    int bd, bmx, bmy, cyc, nd;
    logic [2:0] emx, emy;
    model(bd, bmx, bmy);
    emx = 3'(bmx);
    emy = 3'(bmy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0; lat = -1; nd = 0;
    while (cyc < LAT + 8) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == pa - 1) || (cyc == pb - 1);
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc;
      end
    end
    start = 1'b0;
    check({tag, "_ndone"}, 32'(nd), 32'd1);
`ifdef ME_EARLY_TERM_EN
    check({tag, "_lat_bound"}, 32'((lat >= 0) && (lat <= LAT)), 32'd1);
`else
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
`endif
    check({tag, "_dist"}, 32'(best_dist), 32'(bd));
    check({tag, "_mvx"}, 32'(mv_x), 32'(emx));
    check({tag, "_mvy"}, 32'(mv_y), 32'(emy));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    fill_const(8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_r", 32'(addr_r), 32'd0);
    check("rst_addr_s", 32'(addr_s), 32'd0);
    check("rst_dist", 32'(best_dist), 32'd0);
    check("rst_mv", 32'({mv_x, mv_y}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-equal frames: every SAD is zero, the tie keeps (-2,-2).
    fill_const(8'h10, 8'h10);
    run_test("t1", -1, -1, lat1);
    check("t1_dist_k", 32'(best_dist), 32'd0);
    check("t1_mv_k", 32'({mv_x, mv_y}), 32'({3'b110, 3'b110}));

    // Block planted at cx=3, cy=1 in a 0xFF window.
    fill_const(8'h00, 8'hFF);
    for (int py = 0; py < BLK; py++)
      for (int px = 0; px < BLK; px++) begin
        r_mem[py*BLK + px] = 8'(py*BLK + px);
        s_mem[(1+py)*WIN + 3 + px] = 8'(py*BLK + px);
      end
    run_test("t2", -1, -1, lat2);
    check("t2_dist_k", 32'(best_dist), 32'd0);
    check("t2_mv_k", 32'({mv_x, mv_y}), 32'({3'b001, 3'b111}));

    // Maximum distance: 16 * 255 with no truncation.
    fill_const(8'hFF, 8'h00);
    run_test("t3", -1, -1, lat3);
    check("t3_dist_k", 32'(best_dist), 32'd4080);

    // Random frames, full range and narrow range (many ties).
    fill_rand(255);
    run_test("rnd_a", -1, -1, latx);
    fill_rand(255);
    run_test("rnd_b", -1, -1, latx);
    fill_rand(3);
    run_test("rnd_c", -1, -1, latx);
    fill_rand(1);
    run_test("rnd_d", -1, -1, latx);

    // Stray starts during RUN and DRAIN are ignored.
    fill_rand(255);
    run_test("t4", 100, 258, latx);

    // Asynchronous reset mid-run, then a clean rerun.
    fill_rand(255);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_dist", 32'(best_dist), 32'd0);
    check("t5_mv", 32'({mv_x, mv_y}), 32'd0);
    check("t5_addr", 32'({addr_r, addr_s}), 32'd0);
    latx = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) latx++;
    end
    check("t5_nodone", 32'(latx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test("t5_rerun", -1, -1, latx);

`ifdef ME_EARLY_TERM_EN
    check("et_t1_lat", 32'(lat1), 32'(LAT));
    check("et_t2_short", 32'((lat2 >= 0) && (lat2 < LAT)), 32'd1);
    check("et_t3_bound", 32'((lat3 >= 0) && (lat3 <= LAT)), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
